// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the bitscan encoder: FSM state encoding,
// default width and the one-hot clear-mask builder.
package bitscan_pkg;

  localparam int BITSCAN_N_DEFAULT = 4;
  localparam int BITSCAN_N_MAX     = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } bitscan_state_e;

  function automatic logic [BITSCAN_N_MAX-1:0] clr_mask(input int unsigned idx);
    logic [BITSCAN_N_MAX-1:0] one;
    one = {{(BITSCAN_N_MAX-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/bitscan_encoder_prio_find.sv
// Combinational first-set-bit finder. Scan order is lowest bit first unless
// BITSCAN_MSB_FIRST_EN is defined, in which case the highest set bit wins.
module prio_find #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_single
);

  // Priority index: the last match in loop order wins.
  always_comb begin
    o_idx = '0;
`ifdef BITSCAN_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      o_idx = i_vec[i] ? W'(i) : o_idx;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = i_vec[i] ? W'(i) : o_idx;
    end
`endif
  end

  // A nonzero vector with its lowest set bit removed is empty iff one bit is set.
  assign o_single = (i_vec != '0) && ((i_vec & (i_vec - {{(N-1){1'b0}}, 1'b1})) == '0);

endmodule

// File: rtl/bitscan_encoder.sv
// Handshaked multi-hot to binary-index encoder: one index beat per set bit.
// Define BITSCAN_MSB_FIRST_EN to emit indices highest bit first.
module bitscan_encoder
  import bitscan_pkg::*;
#(
  parameter  int N = BITSCAN_N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_zero
);

  bitscan_state_e r_state;
  bitscan_state_e w_state_nxt;
  logic [N-1:0]   r_pend;
  logic [N-1:0]   w_pend_nxt;
  logic           r_zflag;
  logic           w_zflag_nxt;
  logic [W-1:0]   w_idx;
  logic           w_single;
  logic [N-1:0]   w_clr;

  prio_find #(.N(N)) u_prio_find (
    .i_vec    (r_pend),
    .o_idx    (w_idx),
    .o_single (w_single)
  );

  assign w_clr     = N'(clr_mask(int'(w_idx)));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == SCAN);
  assign out_idx   = w_idx;
  assign out_last  = r_zflag | w_single;
  assign out_zero  = r_zflag;

  // Next-state logic: accept in IDLE, retire one bit per beat handshake in SCAN.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_zflag_nxt = r_zflag;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = SCAN;
          w_pend_nxt  = in_vec;
          w_zflag_nxt = (in_vec == '0);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (out_ready) begin
          w_pend_nxt = r_pend & ~w_clr;
          if (out_last) begin
            // Leave nothing behind so idle outputs read as zero.
            w_state_nxt = IDLE;
            w_pend_nxt  = '0;
            w_zflag_nxt = 1'b0;
          end else begin
            w_state_nxt = SCAN;
          end
        end else begin
          w_state_nxt = SCAN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pend_nxt  = '0;
        w_zflag_nxt = 1'b0;
      end
    endcase
  end

  // State and pending-vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_zflag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_zflag <= w_zflag_nxt;
    end
  end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Self-checking bench for bitscan_encoder: directed cases plus random vectors
// against a queue-based beat model and a decode-and-OR closed loop.
module tb_bitscan_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_zero;

  int n_checks;
  int n_errors;

  bitscan_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected beat indices, in emission order, for a nonzero vector.
  function automatic void model_order(input logic [N-1:0] v, output int q[$]);
    q = {};
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef BITSCAN_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
  endfunction

  // Send one vector and consume all beats. first_stall: forced stall cycles
  // before the first beat; rnd_stall: random out_ready afterwards.
  task automatic run_vec(input logic [N-1:0] v, input int first_stall, input bit rnd_stall,
                         input int stop_after);
    int          q[$];
    int          nb;
    int          stalls;
    logic [N-1:0] acc;
    bit          take;
    model_order(v, q);
    if (v == '0) q.push_back(0);
    nb  = q.size();
    acc = '0;
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = N'($urandom);
    stalls   = 0;
    for (int b = 0; b < nb; b++) begin
      take = 1'b0;
      while (!take) begin
        @(negedge clk);
        check("beat_valid", 32'(out_valid), 32'd1);
        check("beat_in_ready", 32'(in_ready), 32'd0);
        check("beat_idx", 32'(out_idx), 32'(q[b]));
        check("beat_last", 32'(out_last), 32'(b == nb - 1));
        check("beat_zero", 32'(out_zero), 32'(v == '0));
        if (stalls < first_stall) take = 1'b0;
        else if (rnd_stall) take = 1'($urandom_range(0, 1));
        else take = 1'b1;
        stalls++;
        out_ready = take;
        in_valid  = (b == nb - 1 && take) ? 1'b0 : 1'($urandom_range(0, 1));
        in_vec    = N'($urandom);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
      end
      if (v != '0) acc = acc | N'(1 << out_idx_hist(q[b]));
      if (stop_after > 0 && b + 1 == stop_after) return;
    end
    @(negedge clk);
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("loop_or", 32'(acc), 32'(v));
  endtask

  // Index actually observed for the consumed beat (captured on handshake).
  int last_taken_idx;
  function automatic int out_idx_hist(input int dummy);
    return last_taken_idx + 0 * dummy;
  endfunction
  always @(posedge clk) if (out_valid && out_ready) last_taken_idx <= int'(out_idx);

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);

    run_vec(4'b0100, 0, 1'b0, 0);
    run_vec(4'b1011, 3, 1'b0, 0);
    run_vec(4'b0000, 0, 1'b0, 0);
    run_vec(4'b1010, 1, 1'b0, 0);
    run_vec(4'b1111, 0, 1'b1, 0);

    run_vec(4'b1111, 0, 1'b0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(4'b0001, 0, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_vec(N'($urandom), $urandom_range(0, 2), 1'b1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bitscan_encoder.md
Name: bitscan_encoder

Overview:
- Sequential, handshaked N-to-log2(N) encoder. It is the inverse companion of the 2x4 decoder in the combinational library.
- Accepts a multi-hot request vector and emits the index of every set bit, one index per output beat, in priority order. The last beat is flagged.
- Sits between request-collection logic and any consumer that takes binary indices, e.g. a decoder-driven select bus.

Parameters:
- N, 4, input vector width; must be a power of two, N >= 2.
- W, $clog2(N), output index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_vec is valid this cycle
- in_ready  output  1  block can accept a vector
- in_vec  input  N  request vector (multi-hot, one-hot or zero)
- out_valid  output  1  out_idx/out_last/out_zero are valid
- out_ready  input  1  consumer accepts the current beat
- out_idx  output  W  binary index of the current set bit
- out_last  output  1  current beat is the final beat for this vector
- out_zero  output  1  accepted vector was all zeros

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, pend=0, out_valid=0, out_idx=0, out_last=0, out_zero=0, in_ready=1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- IDLE -> SCAN on in_valid&&in_ready. in_vec is registered into pend. The zero flag zflag is set to (in_vec==0).
- Latency: vector accepted at edge T; first beat has out_valid=1 in the cycle after T.
- In SCAN:
  - out_idx = index of the lowest set bit of pend.
  - out_last = 1 when pend has exactly one bit set, or when zflag=1.
  - out_zero = zflag.
- Zero vector: exactly one beat, with out_idx=0, out_zero=1, out_last=1.
- Beat handshake is out_valid&&out_ready. On a handshake the indexed bit of pend is cleared. If out_last=1, the block returns to IDLE and out_valid is 0 the next cycle.
- Backpressure: while out_valid&&!out_ready, out_idx, out_last and out_zero hold stable and pend is unchanged.
- Throughput: a vector with k set bits takes k beats, plus one IDLE cycle before the next accept. in_ready is never high in SCAN, so there is no overlap.
- in_vec is ignored when in_ready=0. in_valid may drop at any time without effect.
- All-ones vector (N=4, 4'b1111): four beats with out_idx 0,1,2,3; out_last=1 only on index 3.
- Reset asserted mid-SCAN: immediately clears pend, drops out_valid and returns to IDLE. No partial beat completes.
- Outputs are registered state or combinational from registered pend only. There is no combinational path from in_* to out_* or from out_ready to in_ready.

Optional Feature:
- Macro: BITSCAN_MSB_FIRST_EN.
- Defined: scan order is highest set bit first. out_idx is the index of the most significant set bit of pend. 4'b1010 emits 3 then 1.
- Undefined (default): lowest set bit first. 4'b1010 emits 1 then 3.
- Handshake, latency and the zero-vector behaviour are identical in both builds.

Decomposition:
- Package bitscan_pkg holds:
  - the state typedef enum {IDLE, SCAN};
  - localparam BITSCAN_N_DEFAULT=4;
  - a function computing the onehot-clear mask from an index.
- One sub-module, prio_find (parameter N), is natural. It is a pure combinational first-set-bit finder. Its outputs are idx[W-1:0] and single (exactly one bit set). The order select follows BITSCAN_MSB_FIRST_EN.

Test Plan:
- Reset then idle: rst_n low for 3 cycles then high -> in_ready=1, out_valid=0, out_idx=0.
- One-hot: in_vec=4'b0100 accepted, out_ready=1 -> single beat, out_idx=2, out_last=1, out_zero=0. in_ready=1 two cycles after accept.
- Multi-hot with backpressure: in_vec=4'b1011, out_ready low for 3 cycles, then high -> beats out_idx 0,1,3 with out_last only on 3. Outputs stay stable during the stall. With BITSCAN_MSB_FIRST_EN the beats are 3,1,0.
- Zero vector: in_vec=4'b0000 -> one beat, out_zero=1, out_last=1, out_idx=0.
- Reset mid-scan: in_vec=4'b1111, assert rst_n after the second beat -> out_valid=0 asynchronously. After release, in_ready=1 and a new vector 4'b0001 yields out_idx=0, out_last=1.
- Closed loop with the 2x4 decoder: for each of 1..15 random vectors, decode every out_idx and OR the results -> the OR equals the original in_vec.
